// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the rotation-mode CORDIC datapath.
// Fixed-point format is signed Q2.13 (value = raw / 8192).
package cordic_pkg;

  localparam int W       = 16;
  localparam int K       = 4975;   // 0.60725 * 8192, inverse CORDIC gain
  localparam int HALF_PI = 12868;
  localparam int PI      = 25736;

  // atan(2^-i) in Q2.13 for i = 0..15
  localparam int ATAN_TBL [16] = '{
    6434, 3798, 2007, 1019, 511, 256, 128, 64,
    32,   16,   8,    4,    2,   1,   0,   0
  };

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational atan(2^-i) lookup, 4-bit index to W-bit Q2.13.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W = cordic_pkg::W
) (
  input  logic        [3:0]   idx,
  output logic signed [W-1:0] atan
);

  // Table lookup, truncated/extended to the datapath width
  always_comb begin
    atan = W'(ATAN_TBL[idx]);
  end

endmodule

// File: rtl/cordic_datapath.sv
// cordic_datapath: rotation-mode CORDIC computing cos/sin of a Q2.13 angle
// in 16 micro-rotations, driven by the controller's ld/init/fin strobes.
// Optional feature macro: CORDIC_QUAD_EXT_EN (pre-rotation to cover +/-pi).
module cordic_datapath
  import cordic_pkg::*;
#(
  parameter int W = cordic_pkg::W
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                ld,
  input  logic                init,
  input  logic                fin,
  input  logic signed [W-1:0] ang_in,
  output logic        [3:0]   itr,
  output logic signed [W-1:0] cos_out,
  output logic signed [W-1:0] sin_out,
  output logic                valid
);

  localparam logic signed [W-1:0] K_W       = W'(K);
  localparam logic signed [W-1:0] HALF_PI_W = W'(HALF_PI);
  localparam logic signed [W-1:0] PI_W      = W'(PI);

  logic signed [W-1:0] x, y, z;
  logic                neg;

  logic signed [W-1:0] atan_i;
  logic signed [W-1:0] x_sh, y_sh;
  logic signed [W-1:0] x_nxt, y_nxt, z_nxt;
  logic signed [W-1:0] z_start;
  logic                neg_start;

  cordic_atan_rom #(.W(W)) u_atan_rom (
    .idx  (itr),
    .atan (atan_i)
  );

  // One micro-rotation from the current (pre-update) x, y, z
  always_comb begin
    x_sh  = x >>> itr;
    y_sh  = y >>> itr;
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (!z[W-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_i;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_i;
    end
  end

`ifdef CORDIC_QUAD_EXT_EN
  // Fold angles beyond +/-pi/2 by pi; the result is negated back at capture
  always_comb begin
    z_start   = ang_in;
    neg_start = 1'b0;
    if (ang_in > HALF_PI_W) begin
      z_start   = ang_in - PI_W;
      neg_start = 1'b1;
    end else if (ang_in < -HALF_PI_W) begin
      z_start   = ang_in + PI_W;
      neg_start = 1'b1;
    end
  end
`else
  // No pre-rotation: angle used as-is, result never negated
  always_comb begin
    z_start   = ang_in;
    neg_start = 1'b0;
  end
`endif

  // Iteration state: start has priority over step; otherwise hold
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      x   <= '0;
      y   <= '0;
      z   <= '0;
      itr <= '0;
      neg <= 1'b0;
    end else if (ld && init) begin
      x   <= K_W;
      y   <= '0;
      z   <= z_start;
      itr <= '0;
      neg <= neg_start;
    end else if (ld) begin
      x   <= x_nxt;
      y   <= y_nxt;
      z   <= z_nxt;
      itr <= itr + 4'd1;
    end
  end

  // Result capture on fin sees pre-update x/y; a start clears valid
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cos_out <= '0;
      sin_out <= '0;
      valid   <= 1'b0;
    end else begin
      if (fin) begin
        cos_out <= neg ? -x : x;
        sin_out <= neg ? -y : y;
        valid   <= 1'b1;
      end
      if (ld && init) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_datapath.sv
// tb_cordic_datapath: directed scoreboard bench for cordic_datapath.
// Expected results are pushed when fin is issued; a monitor pops on the
// rising edge of valid and compares within a +/-4 LSB tolerance.
module tb_cordic_datapath;
  import cordic_pkg::*;

  localparam int TOL = 4;

  logic                clk;
  logic                rst_b;
  logic                ld;
  logic                init;
  logic                fin;
  logic signed [W-1:0] ang_in;
  logic        [3:0]   itr;
  logic signed [W-1:0] cos_out;
  logic signed [W-1:0] sin_out;
  logic                valid;

  typedef struct {
    int    c;
    int    s;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  logic prev_valid = 1'b0;

  cordic_datapath #(.W(W)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .ld      (ld),
    .init    (init),
    .fin     (fin),
    .ang_in  (ang_in),
    .itr     (itr),
    .cos_out (cos_out),
    .sin_out (sin_out),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v, input int tol);
    checks++;
    if ((act - exp_v > tol) || (exp_v - act > tol)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp_v, tol);
    end
  endtask

  // Monitor: one result per rising edge of valid
  always @(negedge clk) begin
    exp_t e;
    if (valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got cos %0d sin %0d expected none", cos_out, sin_out);
      end else begin
        e = sb.pop_front();
        n_pop++;
        chk({e.nm, "_cos"}, int'(cos_out), e.c, TOL);
        chk({e.nm, "_sin"}, int'(sin_out), e.s, TOL);
      end
    end
    prev_valid = valid;
  end

  // Full start/16 steps/fin sequence; abort_at > 0 resets after that step
  task automatic run(input string nm, input int ang, input int ec, input int es,
                     input bit valid_before, input int abort_at);
    exp_t e;
    @(negedge clk);
    if (valid_before) chk({nm, "_valid_before"}, int'(valid), 1, 0);
    ld     = 1'b1;
    init   = 1'b1;
    ang_in = W'(ang);
    @(negedge clk);
    chk({nm, "_valid_clr"}, int'(valid), 0, 0);
    chk({nm, "_itr_start"}, int'(itr), 0, 0);
    init   = 1'b0;
    ang_in = W'($urandom);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ang_in = W'($urandom);
      chk($sformatf("%s_itr%0d", nm, k), int'(itr), k % 16, 0);
      if (k == abort_at) begin
        ld    = 1'b0;
        rst_b = 1'b0;
        #1;
        chk({nm, "_rst_itr"}, int'(itr), 0, 0);
        chk({nm, "_rst_cos"}, int'(cos_out), 0, 0);
        chk({nm, "_rst_sin"}, int'(sin_out), 0, 0);
        chk({nm, "_rst_valid"}, int'(valid), 0, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk({nm, "_post_rst_valid"}, int'(valid), 0, 0);
        return;
      end
    end
    ld  = 1'b0;
    fin = 1'b1;
    chk({nm, "_valid_pre_fin"}, int'(valid), 0, 0);
    e.c = ec;
    e.s = es;
    e.nm = nm;
    sb.push_back(e);
    n_push++;
    @(negedge clk);
    fin = 1'b0;
    chk({nm, "_valid_edge17"}, int'(valid), 1, 0);
  endtask

  initial begin
    rst_b  = 1'b0;
    ld     = 1'b0;
    init   = 1'b0;
    fin    = 1'b0;
    ang_in = '0;
    #1;
    chk("reset_itr", int'(itr), 0, 0);
    chk("reset_cos", int'(cos_out), 0, 0);
    chk("reset_sin", int'(sin_out), 0, 0);
    chk("reset_valid", int'(valid), 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;

    run("ang0",     0,      8192, 0,     1'b0, 0);
    run("pi6",      4289,   7094, 4096,  1'b1, 0);
    run("pi2",      12868,  0,    8192,  1'b1, 0);
    run("abort",    4289,   7094, 4096,  1'b1, 7);
    run("mpi4",     -6434,  5793, -5793, 1'b0, 0);
`ifdef CORDIC_QUAD_EXT_EN
    run("q3pi4",    19302,  -5793, 5793, 1'b1, 0);
    run("qm3pi4",   -19302, -5793, -5793, 1'b1, 0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", n_pop, n_push, 0);
    chk("hold_valid", int'(valid), 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cordic_datapath.md
# cordic_datapath

Rotation-mode CORDIC datapath that computes cosine and sine of a fixed-point angle in 16 micro-rotations. It sits directly downstream of the CORDIC control FSM and consumes that FSM's `ld`, `init` and `fin` strobes. It returns the iteration index `itr`, from which the FSM decides when to finish. The result is registered on `fin` and held valid until the next start.

## Interface
- `W`, default 16: datapath width; angle and results are signed Q2.13 (value = raw/8192).
- `clk  in  1`: single clock, rising edge.
- `rst_b  in  1`: asynchronous, active-low reset.
- `ld  in  1`: load/step strobe from the controller.
- `init  in  1`: with `ld`, start a new computation.
- `fin  in  1`: capture the result (one-cycle pulse from the controller).
- `ang_in  in  W`: signed Q2.13 angle in radians; sampled only on `init & ld`.
- `itr  out  4`: current iteration index, registered.
- `cos_out  out  W`: signed Q2.13 cosine, registered.
- `sin_out  out  W`: signed Q2.13 sine, registered.
- `valid  out  1`: result valid, registered.

## Operation
- Internal registers: `x`, `y`, `z` (W bits, signed), `itr` (4 bits), `neg` (1 bit).
- Priority: `init & ld`, then `ld`, then idle (hold).
- **Start** (`init & ld`):
  - `x ← K = 4975` (0.60725·8192), `y ← 0`, `z ← ang_in`, `itr ← 0`.
  - `neg ← 0`, `valid ← 0`.
- **Step** (`ld & !init`):
  - `d = +1` if `z ≥ 0`, else `-1`.
  - `x ← x − d·(y >>> itr)`, `y ← y + d·(x >>> itr)`, `z ← z − d·atan[itr]`. All right-hand sides use pre-update values.
  - Shifts are arithmetic. Add/sub is W-bit two's-complement wrap, with no saturation.
  - `itr ← itr + 1`, wrapping 15 → 0.
- **atan table** (Q2.13, i = 0..15): 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0.
- **Capture** (`fin`):
  - `cos_out ← x`, `sin_out ← y` (negated if `neg`), `valid ← 1`.
  - Evaluated in parallel with the ld/init logic, so it captures pre-update `x` and `y`.
- `valid` stays high until the next start. `ang_in` is ignored at all times other than start.
- `ld` held beyond 16 steps keeps iterating with the wrapped `itr`. This is not an error; the controller prevents it.

## Timing
- Reset: `x`, `y`, `z`, `itr`, `neg`, `cos_out`, `sin_out` and `valid` are all 0, immediately and asynchronously.
- Nominal sequence:
  - Edge 0: start.
  - Edges 1–16: steps with `itr` = 0..15. After edge 16, `itr` = 0.
  - `fin` is high in the following cycle. At edge 17 the outputs are captured, so `valid = 1` from edge 17 onward.
- Latency from the start edge to `valid`: 17 clocks.
- A reset asserted mid-computation aborts the computation. Outputs return to 0 and `valid` stays 0 until the next full sequence.
- A start while `valid = 1` clears `valid` on the same edge.

## Configuration
- Macro: `CORDIC_QUAD_EXT_EN`.
- **Defined:** input range is extended to ±π (±25736) by pre-rotation at start.
  - If `ang_in > 12868`: `z ← ang_in − 25736`, `neg ← 1`.
  - If `ang_in < −12868`: `z ← ang_in + 25736`, `neg ← 1`.
  - At capture, `cos_out` and `sin_out` are two's-complement negated when `neg = 1`.
- **Undefined:** no pre-rotation. `neg` is tied to 0. Valid input range is ±π/2 (±12868); results outside that range are deterministic but not meaningful.

## Structure
- Package `cordic_pkg` holds:
  - `W`, `K = 4975`, `HALF_PI = 12868`, `PI = 25736`.
  - The 16-entry atan constant array.
- One combinational sub-module, `cordic_atan_rom`: 4-bit index in, W-bit atan value out.
- Everything else lives in `cordic_datapath`.

## Test plan
- Reset, then `ang_in = 0` and a start followed by 16 steps and `fin` → `cos_out ≈ 8192`, `sin_out ≈ 0` (±4 LSB), `valid` high at edge 17.
- `ang_in = 4289` (π/6) → `cos_out ≈ 7094`, `sin_out ≈ 4096` (±4 LSB). Also check `itr` reads 0..15 across the steps and returns to 0.
- `ang_in = −6434` (−π/4) → `cos_out ≈ 5793`, `sin_out ≈ −5793` (±4 LSB).
- Assert `rst_b` low after step 7 → all outputs 0 immediately. A new full sequence afterwards gives the correct result.
- With `valid = 1`, issue a new start at `ang_in = 12868` → `valid` drops on the start edge. Final result `cos_out ≈ 0`, `sin_out ≈ 8192`.
- `CORDIC_QUAD_EXT_EN` defined, `ang_in = 19302` (3π/4) → `cos_out ≈ −5793`, `sin_out ≈ 5793`. Undefined build, same stimulus → no negation applied; the test checks only that the result is deterministic.
